axis_s_fifo: RTL and testbench
==============================

// Module: axis_s_fifo
// PURPOSE
//  AXI-Stream slave (receiver) for the simple 32-bit AXIS link; sink side of
//  the single-beat master. Accepts beats into a DEPTH-entry first-word-fall-
//  through FIFO, presents them to a local consumer via a valid/pop interface,
//  counts beats per packet and reports packet length on tlast.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of 2, >= 2
//  ADDR_W   2   log2(DEPTH); pointer width
//  CNT_W    16  width of beat counter / packet length
// PORTS
//  aclk       in   1       single clock, all logic on posedge
//  areset_n   in   1       asynchronous active-low reset
//  tvalid     in   1       AXIS beat valid from master
//  tready     out  1       AXIS ready to master
//  tlast      in   1       AXIS last beat of packet
//  tdata      in   32      AXIS payload
//  rd_en      in   1       consumer pop request
//  data_valid out  1       FIFO not empty; data_out/data_last valid
//  data_out   out  32      head-of-FIFO payload
//  data_last  out  1       head-of-FIFO tlast flag
//  level      out  ADDR_W+1 current FIFO occupancy 0..DEPTH
//  pkt_done   out  1       1-cycle pulse: tlast beat accepted
//  pkt_len    out  CNT_W   beats in last completed packet
// BEHAVIOUR
//  - Reset (areset_n low, async): wr/rd ptrs=0, level=0, word_cnt=0,
//    pkt_len=0, pkt_done=0; so tready=1, data_valid=0, data_out=0,
//    data_last=0. Reset mid-packet discards FIFO contents and partial count.
//  - tready = (level != DEPTH), combinational from registered level only;
//    no dependence on tvalid.
//  - handshake = tvalid & tready; on posedge with handshake, {tlast,tdata}
//    written at wr_ptr, wr_ptr+1 (wraps mod DEPTH).
//  - pop = rd_en & data_valid; rd_en while empty ignored, no ptr change.
//  - data_valid = (level != 0); data_out/data_last = mem[rd_ptr] when valid,
//    forced 0 when empty. Latency: beat accepted at edge N visible on data_out
//    in cycle after N (1 cycle, fall-through).
//  - level: +1 on handshake only, -1 on pop only, unchanged on both/neither.
//    Simultaneous push+pop when full impossible (tready=0); push+pop when
//    empty: push happens, pop ignored, level->1.
//  - word_cnt: +1 per handshake with tlast=0, saturates at all-ones. On
//    handshake with tlast=1: pkt_len <= sat(word_cnt+1), word_cnt <= 0,
//    pkt_done=1 next cycle only. Back-to-back tlast beats give consecutive
//    pulses with pkt_len=1 each.
//  - tdata/tlast sampled only on handshake; changes while tvalid=0 or
//    tready=0 have no effect. No overflow possible by construction.
// TESTING
//  1. Reset then idle -> tready=1, data_valid=0, level=0, data_out=0.
//  2. Single beat tdata=32'hDEADBEEF, tlast=1, rd_en=0 -> next cycle
//     data_valid=1, data_out=DEADBEEF, data_last=1, pkt_done pulse, pkt_len=1.
//  3. 5 beats 1..5 back-to-back, tlast on 5th, DEPTH=4, rd_en=0 -> tready
//     drops after 4th; 5th held; pop one -> 5th accepted, pkt_len=5.
//  4. Continuous stream with rd_en=1 every cycle -> tready stays 1, level
//     <=1, data_out order equals input order, no beat lost.
//  5. Pop on empty plus push same cycle (tdata=32'h0000_00A5) -> level=1,
//     data_out=A5 next cycle.
//  6. Assert areset_n low mid-packet with level=3 -> immediately level=0,
//     data_valid=0, tready=1; next packet of 2 beats gives pkt_len=2.

Source files
------------

// File: rtl/axis_s_fifo.sv
// axis_s_fifo
// AXI-Stream slave for the 32-bit AXIS link. Incoming beats land in a small
// first-word-fall-through FIFO. A local consumer drains them through a
// valid/pop interface. Beats are also counted per packet, and the length of
// each completed packet is reported when its tlast beat is accepted.
//
// Ports
//   aclk        clock, all logic on the rising edge
//   areset_n    asynchronous active-low reset
//   tvalid      AXIS beat valid from the master
//   tready      AXIS ready back to the master (FIFO not full)
//   tlast       AXIS last-beat-of-packet flag
//   tdata       AXIS payload
//   rd_en       consumer pop request
//   data_valid  FIFO not empty; data_out/data_last are meaningful
//   data_out    head-of-FIFO payload (0 when empty)
//   data_last   head-of-FIFO tlast flag (0 when empty)
//   level       current FIFO occupancy, 0..DEPTH
//   pkt_done    one-cycle pulse after a tlast beat is accepted
//   pkt_len     beat count of the most recently completed packet
module axis_s_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              tvalid,
    output logic              tready,
    input  logic              tlast,
    input  logic [31:0]       tdata,
    input  logic              rd_en,
    output logic              data_valid,
    output logic [31:0]       data_out,
    output logic              data_last,
    output logic [ADDR_W:0]   level,
    output logic              pkt_done,
    output logic [CNT_W-1:0]  pkt_len
);

    localparam logic [ADDR_W:0]  FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  LEVEL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    // Each entry holds {tlast, tdata}.
    logic [32:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  word_cnt;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  cnt_next;

    // Ready and valid come only from the registered occupancy. This keeps
    // tready free of any combinational path from tvalid. A pop on an empty
    // FIFO is therefore masked out.
    always_comb begin
        tready     = (level != FULL_LEVEL);
        data_valid = (level != '0);
        push       = tvalid & tready;
        pop        = rd_en & data_valid;
        cnt_next   = (word_cnt == CNT_MAX) ? CNT_MAX : word_cnt + CNT_ONE;
    end

    // Fall-through head. The output is forced to zero while empty, so the
    // consumer never sees stale data from an old entry.
    always_comb begin
        data_out  = '0;
        data_last = 1'b0;
        if (data_valid) begin
            data_out  = mem[rd_ptr][31:0];
            data_last = mem[rd_ptr][32];
        end
    end

    // Storage array. It has no reset, because contents are only observed
    // through data_valid, and that goes low when level is cleared.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= {tlast, tdata};
        end
    end

    // Pointers and occupancy. Both pointers wrap naturally because DEPTH is
    // a power of two. A simultaneous push and pop leaves level unchanged.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Packet accounting.
    // word_cnt holds the number of non-last beats seen so far in the current
    // packet. The tlast beat itself is added when pkt_len is loaded. Both
    // word_cnt and pkt_len saturate instead of wrapping on very long packets.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            word_cnt <= '0;
            pkt_len  <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (push) begin
                if (tlast) begin
                    pkt_len  <= cnt_next;
                    word_cnt <= '0;
                    pkt_done <= 1'b1;
                end else begin
                    word_cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_s_fifo.sv
// tb_axis_s_fifo
// Directed bench for axis_s_fifo. Inputs change 1 ns after a rising edge.
// Outputs are sampled 1 ns after the following edge, so every expectation
// describes the state left behind by the edge just taken.
module tb_axis_s_fifo;

    logic        aclk;
    logic        areset_n;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [31:0] tdata;
    logic        rd_en;
    logic        data_valid;
    logic [31:0] data_out;
    logic        data_last;
    logic [2:0]  level;
    logic        pkt_done;
    logic [15:0] pkt_len;

    int check_count = 0;
    int error_count = 0;

    axis_s_fifo #(.DEPTH(4), .ADDR_W(2), .CNT_W(16)) dut (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .tvalid     (tvalid),
        .tready     (tready),
        .tlast      (tlast),
        .tdata      (tdata),
        .rd_en      (rd_en),
        .data_valid (data_valid),
        .data_out   (data_out),
        .data_last  (data_last),
        .level      (level),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len)
    );

    // 10 ns clock with rising edges at 5, 15, 25, ...
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Drive one set of inputs. The values are held until the next call.
    task automatic applyStimulus(input logic tv, input logic tl,
                                 input logic [31:0] td, input logic re);
        tvalid = tv;
        tlast  = tl;
        tdata  = td;
        rd_en  = re;
    endtask

    // Advance one clock edge, then settle away from that edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        areset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        // 1. Reset and idle.
        tick();
        checkOutput("rst_tready", 32'(tready), 32'd1);
        checkOutput("rst_valid", 32'(data_valid), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_data", data_out, 32'd0);
        checkOutput("rst_last", 32'(data_last), 32'd0);
        checkOutput("rst_done", 32'(pkt_done), 32'd0);
        checkOutput("rst_len", 32'(pkt_len), 32'd0);
        areset_n = 1'b1;
        tick();
        checkOutput("idle_level", 32'(level), 32'd0);

        // 2. Single-beat packet.
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("one_valid", 32'(data_valid), 32'd1);
        checkOutput("one_data", data_out, 32'hDEADBEEF);
        checkOutput("one_last", 32'(data_last), 32'd1);
        checkOutput("one_done", 32'(pkt_done), 32'd1);
        checkOutput("one_len", 32'(pkt_len), 32'd1);
        checkOutput("one_level", 32'(level), 32'd1);
        tick();
        checkOutput("one_done_drop", 32'(pkt_done), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("one_pop_level", 32'(level), 32'd0);
        checkOutput("one_pop_data", data_out, 32'd0);
        // A pop on an empty FIFO must change nothing.
        tick();
        checkOutput("empty_pop_level", 32'(level), 32'd0);
        checkOutput("empty_pop_valid", 32'(data_valid), 32'd0);

        // 3. Five beats into a four-entry FIFO with no consumer.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'(i), 1'b0);
            tick();
            checkOutput("fill_level", 32'(level), 32'(i));
        end
        checkOutput("full_tready", 32'(tready), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'd5, 1'b0);
        tick();
        checkOutput("held_level", 32'(level), 32'd4);
        checkOutput("held_done", 32'(pkt_done), 32'd0);
        checkOutput("held_head", data_out, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'd5, 1'b1);
        tick();
        checkOutput("pop1_level", 32'(level), 32'd3);
        checkOutput("pop1_tready", 32'(tready), 32'd1);
        checkOutput("pop1_head", data_out, 32'd2);
        checkOutput("pop1_done", 32'(pkt_done), 32'd0);
        tick();
        checkOutput("acc5_level", 32'(level), 32'd3);
        checkOutput("acc5_done", 32'(pkt_done), 32'd1);
        checkOutput("acc5_len", 32'(pkt_len), 32'd5);
        checkOutput("acc5_head", data_out, 32'd3);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("drain_head4", data_out, 32'd4);
        checkOutput("drain_last4", 32'(data_last), 32'd0);
        tick();
        checkOutput("drain_head5", data_out, 32'd5);
        checkOutput("drain_last5", 32'(data_last), 32'd1);
        tick();
        checkOutput("drain_level", 32'(level), 32'd0);

        // 4. Continuous stream with the consumer popping every cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, (i == 7), 32'h100 + 32'(i), 1'b1);
            tick();
            checkOutput("strm_level", 32'(level), 32'd1);
            checkOutput("strm_tready", 32'(tready), 32'd1);
            checkOutput("strm_data", data_out, 32'h100 + 32'(i));
        end
        checkOutput("strm_done", 32'(pkt_done), 32'd1);
        checkOutput("strm_len", 32'(pkt_len), 32'd8);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("strm_empty", 32'(level), 32'd0);

        // 5. Push and pop in the same cycle on an empty FIFO.
        applyStimulus(1'b1, 1'b0, 32'h0000_00A5, 1'b1);
        tick();
        checkOutput("pe_level", 32'(level), 32'd1);
        checkOutput("pe_data", data_out, 32'h0000_00A5);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("pe_drain", 32'(level), 32'd0);

        // 6. Asynchronous reset in the middle of a packet.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h200 + 32'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("mid_level", 32'(level), 32'd3);
        #2;
        areset_n = 1'b0;
        #1;
        checkOutput("ar_level", 32'(level), 32'd0);
        checkOutput("ar_valid", 32'(data_valid), 32'd0);
        checkOutput("ar_tready", 32'(tready), 32'd1);
        checkOutput("ar_data", data_out, 32'd0);
        checkOutput("ar_len", 32'(pkt_len), 32'd0);
        tick();
        areset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h300, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h301, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("post_done", 32'(pkt_done), 32'd1);
        checkOutput("post_len", 32'(pkt_len), 32'd2);
        checkOutput("post_level", 32'(level), 32'd2);
        checkOutput("post_head", data_out, 32'h300);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
